// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution stage (add/sub/and/or/slt).
// Define ALU_MUL_EN to add an iterative shift-add multiply on code 100.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd2
  } state_t;
`endif

  state_t state, nxt;

  logic             accept;
  logic             slt;
  logic [WIDTH-1:0] op_res;
  logic             op_ill;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign slt       = $signed(a) < $signed(b);

`ifdef ALU_MUL_EN
  logic             is_mul;
  logic             last;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;

  assign is_mul  = (alu_operation == 3'b100);
  assign last    = (cnt == CW'(1));
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

  // single-cycle operation decode; unsupported codes read as illegal
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (alu_operation)
      3'b000:  op_res = a + b;
      3'b001:  op_res = a - b;
      3'b010:  op_res = a & b;
      3'b011:  op_res = a | b;
      3'b111:  op_res = {{(WIDTH-1){1'b0}}, slt};
      default: op_ill = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          nxt = is_mul ? BUSY : HOLD;
`else
          nxt = HOLD;
`endif
        end
      end
`ifdef ALU_MUL_EN
      BUSY: if (last) nxt = HOLD;
`endif
      HOLD: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // result registers and multiply datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (accept) begin
        result  <= op_res;
        zero    <= (op_res == '0);
        illegal <= op_ill;
      end else if (state == BUSY) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (last) begin
          result  <= acc_nxt;
          zero    <= (acc_nxt == '0);
          illegal <= 1'b0;
        end
      end
`else
      if (accept) begin
        result  <= op_res;
        zero    <= (op_res == '0);
        illegal <= op_ill;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit.
// Multiply expectations follow ALU_MUL_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_operation;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_MUL_EN
  localparam int          MUL_LAT = 33;
  localparam logic [31:0] MUL_RES = 32'h0005000F;
  localparam logic        MUL_Z   = 1'b0;
  localparam logic        MUL_ILL = 1'b0;
`else
  localparam int          MUL_LAT = 1;
  localparam logic [31:0] MUL_RES = 32'h0;
  localparam logic        MUL_Z   = 1'b1;
  localparam logic        MUL_ILL = 1'b1;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input  logic [2:0]  op,
                       input  logic [31:0] x,
                       input  logic [31:0] y,
                       input  logic        rdy,
                       output int          lat,
                       output int          busy_rdy);
    @(negedge clk);
    alu_operation = op;
    a             = x;
    b             = y;
    in_valid      = 1'b1;
    out_ready     = rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    busy_rdy = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_rdy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string       tag,
                     input logic [2:0]  op,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] er,
                     input logic        ez,
                     input logic        ei);
    int lat;
    int br;
    issue(op, x, y, 1'b1, lat, br);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_res"}, result, er);
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_ill"}, 32'(illegal), 32'(ei));
    @(posedge clk);
    #1;
    check({tag, "_ovdrop"}, 32'(out_valid), 0);
    check({tag, "_irdy"}, 32'(in_ready), 1);
  endtask

  initial begin
    int lat;
    int br;
    rst           = 1'b1;
    in_valid      = 1'b0;
    alu_operation = 3'b000;
    a             = '0;
    b             = '0;
    out_ready     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_irdy", 32'(in_ready), 1);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_res", result, 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_ill", 32'(illegal), 0);
    rst = 1'b0;

    run("add", 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
    run("sub", 3'b001, 32'h00000005, 32'h00000005, 32'h0, 1'b1, 1'b0);
    run("and", 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
    run("or", 3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);
    run("slt1", 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h1, 1'b0, 1'b0);
    run("slt2", 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    run("slt3", 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0);
    run("ill5", 3'b101, 32'h12345678, 32'h1, 32'h0, 1'b1, 1'b1);
    run("ill6", 3'b110, 32'h12345678, 32'h1, 32'h0, 1'b1, 1'b1);
    run("add2", 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b1, 1'b0);

    issue(3'b100, 32'h00010003, 32'h00000005, 1'b0, lat, br);
    check("mul_lat", lat, MUL_LAT);
    check("mul_busy_irdy", br, 0);
    check("mul_res", result, MUL_RES);
    check("mul_zero", 32'(zero), 32'(MUL_Z));
    check("mul_ill", 32'(illegal), 32'(MUL_ILL));
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_ov", 32'(out_valid), 1);
      check("bp_irdy", 32'(in_ready), 0);
      check("bp_res", result, MUL_RES);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ovdrop", 32'(out_valid), 0);
    check("bp_irdy_back", 32'(in_ready), 1);
    check("bp_res_keep", result, MUL_RES);

    run("or2", 3'b011, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0);

    @(negedge clk);
    alu_operation = 3'b100;
    a             = 32'h00010003;
    b             = 32'h00000005;
    in_valid      = 1'b1;
    out_ready     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_ov", 32'(out_valid), 0);
    check("mrst_irdy", 32'(in_ready), 1);
    check("mrst_res", result, 0);
    check("mrst_zero", 32'(zero), 0);
    check("mrst_ill", 32'(illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst_add", 3'b000, 32'd2, 32'd3, 32'h00000005, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execution unit that consumes the 3-bit ALU operation code produced by the ALU control decoder, together with two operands, and returns a result, zero flag and illegal-code flag. It sits between the control path and the writeback/branch logic and uses a valid/ready handshake on both sides. An optional iterative shift-add multiplier is compiled in behind a macro.

## Interface
- WIDTH, 32, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation and operands presented
- in_ready  output  1  unit can accept; high only in IDLE
- alu_operation  input  3  000 add, 001 sub, 010 and, 011 or, 111 slt, 100 mul (macro only)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result, zero and illegal are valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  registered, 1 when result == 0
- illegal  output  1  registered, 1 when accepted code was unsupported

## Operation
- States: IDLE, BUSY (multiply only), HOLD.
- in_ready = (state == IDLE), combinational from state register only; no dependence on in_valid.
- Accept = in_valid && in_ready at a rising edge; a, b, alu_operation sampled at that edge only.
- Single-cycle codes (000, 001, 010, 011, 111, and all illegal codes): result/zero/illegal registered at accept edge; state IDLE→HOLD.
- add/sub: modulo 2^WIDTH, carry/overflow discarded.
- and/or: bitwise.
- slt: two's-complement signed compare; result = 1 if a < b else 0 (zero-extended to WIDTH); must be correct when a−b overflows.
- Illegal codes (101, 110; 100 when the macro is absent): result = 0, zero = 1, illegal = 1.
- Multiply (100, macro present): IDLE→BUSY at accept; multiplicand, multiplier, WIDTH-iteration counter and accumulator loaded. One shift-add step per edge in BUSY; after the WIDTH-th step the low WIDTH bits of a*b are written to result, zero updated, illegal = 0, BUSY→HOLD.
- HOLD: outputs frozen; out_valid = 1. On an edge with out_ready = 1: HOLD→IDLE, out_valid→0. result/zero/illegal keep their values until the next completion.
- in_valid during BUSY or HOLD is ignored (in_ready = 0); the upstream must hold its request.

## Timing
- Reset (asynchronous, effective immediately, any state including mid-multiply): state = IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, illegal = 0, counter/accumulator cleared; any in-flight operation is discarded.
- Single-cycle latency: out_valid high in the cycle after the accept edge (1 edge).
- Multiply latency: out_valid high after WIDTH+1 edges counted from the accept edge inclusive (33 at WIDTH = 32).
- Minimum issue interval: 2 cycles for single-cycle ops with out_ready held at 1 (accept, HOLD, IDLE→accept again). in_ready rises in the cycle after the out_ready handshake edge.
- out_ready high while out_valid = 0 has no effect.
- Back-pressure: result stable for any number of cycles while out_ready = 0.

## Configuration
- ALU_MUL_EN defined: code 100 is a WIDTH-cycle iterative multiply; BUSY state and multiply datapath are present.
- ALU_MUL_EN undefined: no BUSY state or multiply logic; code 100 is illegal (result 0, zero 1, illegal 1, latency 1).

## Test plan
- add a=0x7FFFFFFF, b=0x00000001, out_ready=1 -> out_valid 1 edge later, result 0x80000000, zero 0, illegal 0; in_ready back to 1 two cycles after accept.
- sub a=b=0x00000005 -> result 0, zero 1; and 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0; or of the same operands -> 0xFFF0FFF0.
- slt a=0xFFFFFFFF, b=0x00000001 -> 1; a=0x80000000, b=0x7FFFFFFF -> 1; a=0x7FFFFFFF, b=0x80000000 -> 0.
- With ALU_MUL_EN: mul a=0x00010003, b=0x00000005 -> result 0x0005000F after 33 edges; in_ready 0 throughout; out_ready held 0 for 3 cycles keeps result and out_valid stable. Without the macro: same stimulus -> illegal 1, result 0, zero 1 after 1 edge.
- Code 101 and 110 -> illegal 1, result 0, zero 1, latency 1.
- rst asserted 10 cycles into a multiply -> out_valid 0, in_ready 1, result 0 immediately; after release an add 2+3 -> 0x00000005 with latency 1.
